// File: rtl/iir_biquad_tdm_if.sv
// Sample stream bundle for iir_biquad_tdm: valid/ready input side plus the
// result pulse side. The filter uses the slave view; the sample source uses master.
interface iir_biquad_tdm_if #(
  parameter int DW  = 12,
  parameter int NCH = 2
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [CHW-1:0]        in_ch;
  logic signed [DW-1:0]  in_data;
  logic                  out_valid;
  logic [CHW-1:0]        out_ch;
  logic signed [DW-1:0]  out_data;
  logic                  out_sat;

  modport master (
    output in_valid, in_ch, in_data,
    input  in_ready, out_valid, out_ch, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_ch, in_data,
    output in_ready, out_valid, out_ch, out_data, out_sat
  );
endinterface

// File: rtl/iir_biquad_tdm.sv
// Direct-form-I biquad, NCH time-multiplexed channels sharing one multiplier.
// One sample is accepted in IDLE, then five MAC cycles (b0,b1,b2,a1,a2) build
// the sum; the last MAC cycle rounds half-up, saturates and writes history.
module iir_biquad_tdm #(
  parameter int DW   = 12,
  parameter int CW   = 16,
  parameter int FRAC = 11,
  parameter int NCH  = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 coef_we,
  input  logic [2:0]           coef_sel,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 clr_state,
  iir_biquad_tdm_if.slave      s_if
);
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACCW = DW + CW + 3;
  localparam int PW   = DW + CW;

  localparam logic signed [ACCW-1:0] ROUND_K = ACCW'(2 ** (FRAC - 1));
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(2 ** (DW - 1) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(2 ** (DW - 1)));
  localparam logic signed [DW-1:0]   Y_MAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   Y_MIN   = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CHW:0]           NCH_L   = (CHW+1)'(NCH);

  // Coefficient order everywhere: 0=b0 1=b1 2=b2 3=a1 4=a2
  localparam logic signed [CW-1:0] COEF_DEF [5] =
    '{CW'(94), CW'(140), CW'(94), CW'(-1213), CW'(268)};

  typedef enum logic [2:0] {S_IDLE, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4} state_t;

  state_t                 state_q, state_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  // Working copy of the accepted sample and its channel history
  logic signed [DW-1:0]   x_q, x_d, x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
  logic [CHW-1:0]         ch_q, ch_d;
  logic                   ch_ok_q, ch_ok_d;
  logic signed [CW-1:0]   coef_sh_q [5];
  logic signed [CW-1:0]   coef_sh_d [5];
  logic signed [CW-1:0]   coef_act_q [5];
  logic signed [CW-1:0]   coef_act_d [5];
  logic                   out_valid_q, out_valid_d;
  logic [CHW-1:0]         out_ch_q, out_ch_d;
  logic signed [DW-1:0]   out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;
  // Per-channel history
  logic signed [DW-1:0]   hx1_q [NCH];
  logic signed [DW-1:0]   hx1_d [NCH];
  logic signed [DW-1:0]   hx2_q [NCH];
  logic signed [DW-1:0]   hx2_d [NCH];
  logic signed [DW-1:0]   hy1_q [NCH];
  logic signed [DW-1:0]   hy1_d [NCH];
  logic signed [DW-1:0]   hy2_q [NCH];
  logic signed [DW-1:0]   hy2_d [NCH];

  logic                   in_ready;
  logic                   accept;
  logic                   in_ch_ok;
  logic signed [DW-1:0]   sel_x1, sel_x2, sel_y1, sel_y2;
  logic signed [CW-1:0]   mac_coef;
  logic signed [DW-1:0]   mac_op;
  logic                   mac_sub;
  logic signed [PW-1:0]   product;
  logic signed [ACCW-1:0] prod_ext, acc_sum, acc_shift;
  logic signed [DW-1:0]   y_res;
  logic                   y_sat;

  // Clearing takes priority over a new sample, so ready drops with clr_state
  assign in_ready = sys_rst && !clr_state && (state_q == S_IDLE);
  assign accept   = in_ready && s_if.in_valid;
  assign in_ch_ok = {1'b0, s_if.in_ch} < NCH_L;

  assign s_if.in_ready  = in_ready;
  assign s_if.out_valid = out_valid_q;
  assign s_if.out_ch    = out_ch_q;
  assign s_if.out_data  = out_data_q;
  assign s_if.out_sat   = out_sat_q;

  // Fetch the addressed channel's history; out-of-range channels read as zero
  always_comb begin
    sel_x1 = '0;
    sel_x2 = '0;
    sel_y1 = '0;
    sel_y2 = '0;
    for (int i = 0; i < NCH; i++) begin
      if (s_if.in_ch == CHW'(i)) begin
        sel_x1 = hx1_q[i];
        sel_x2 = hx2_q[i];
        sel_y1 = hy1_q[i];
        sel_y2 = hy2_q[i];
      end
    end
  end

  // Pick the coefficient/operand pair for the current MAC step
  always_comb begin
    mac_coef = '0;
    mac_op   = '0;
    mac_sub  = 1'b0;
    case (state_q)
      S_MAC0:  begin mac_coef = coef_act_q[0]; mac_op = x_q;  end
      S_MAC1:  begin mac_coef = coef_act_q[1]; mac_op = x1_q; end
      S_MAC2:  begin mac_coef = coef_act_q[2]; mac_op = x2_q; end
      S_MAC3:  begin mac_coef = coef_act_q[3]; mac_op = y1_q; mac_sub = 1'b1; end
      S_MAC4:  begin mac_coef = coef_act_q[4]; mac_op = y2_q; mac_sub = 1'b1; end
      default: ;
    endcase
  end

  // Shared multiplier, accumulate, and the final round/saturate of the sum
  always_comb begin
    product   = PW'(mac_coef) * PW'(mac_op);
    prod_ext  = ACCW'(product);
    acc_sum   = mac_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
    acc_shift = acc_sum >>> FRAC;
    y_res     = acc_shift[DW-1:0];
    y_sat     = 1'b0;
    if (acc_shift > SAT_MAX) begin
      y_res = Y_MAX;
      y_sat = 1'b1;
    end else if (acc_shift < SAT_MIN) begin
      y_res = Y_MIN;
      y_sat = 1'b1;
    end
  end

  // Next-state, coefficient banks, output and history updates
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    x_d         = x_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    ch_d        = ch_q;
    ch_ok_d     = ch_ok_q;
    coef_sh_d   = coef_sh_q;
    coef_act_d  = coef_act_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    hx1_d       = hx1_q;
    hx2_d       = hx2_q;
    hy1_d       = hy1_q;
    hy2_d       = hy2_q;

    // Shadow bank is writable in any state, even while clearing
    if (coef_we) begin
      for (int k = 0; k < 5; k++) begin
        if (coef_sel == 3'(k)) coef_sh_d[k] = coef_data;
      end
    end

    if (clr_state) begin
      state_d = S_IDLE;
      acc_d   = '0;
      for (int i = 0; i < NCH; i++) begin
        hx1_d[i] = '0;
        hx2_d[i] = '0;
        hy1_d[i] = '0;
        hy2_d[i] = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            // Active bank takes the pre-write shadow, so a same-cycle write waits a sample
            coef_act_d = coef_sh_q;
            x_d        = s_if.in_data;
            x1_d       = sel_x1;
            x2_d       = sel_x2;
            y1_d       = sel_y1;
            y2_d       = sel_y2;
            ch_d       = s_if.in_ch;
            ch_ok_d    = in_ch_ok;
            acc_d      = ROUND_K;
            state_d    = S_MAC0;
          end
        end
        S_MAC0: begin acc_d = acc_sum; state_d = S_MAC1; end
        S_MAC1: begin acc_d = acc_sum; state_d = S_MAC2; end
        S_MAC2: begin acc_d = acc_sum; state_d = S_MAC3; end
        S_MAC3: begin acc_d = acc_sum; state_d = S_MAC4; end
        S_MAC4: begin
          acc_d   = '0;
          state_d = S_IDLE;
          if (ch_ok_q) begin
            out_valid_d = 1'b1;
            out_ch_d    = ch_q;
            out_data_d  = y_res;
            out_sat_d   = y_sat;
            for (int i = 0; i < NCH; i++) begin
              if (ch_q == CHW'(i)) begin
                hx2_d[i] = x1_q;
                hx1_d[i] = x_q;
                hy2_d[i] = y1_q;
                hy1_d[i] = y_res;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control, datapath, coefficient and output registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      x_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      ch_q        <= '0;
      ch_ok_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        coef_sh_q[k]  <= COEF_DEF[k];
        coef_act_q[k] <= COEF_DEF[k];
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      ch_q        <= ch_d;
      ch_ok_q     <= ch_ok_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      coef_sh_q   <= coef_sh_d;
      coef_act_q  <= coef_act_d;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_hist
    // History registers for one channel
    always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
        hx1_q[gi] <= '0;
        hx2_q[gi] <= '0;
        hy1_q[gi] <= '0;
        hy2_q[gi] <= '0;
      end else begin
        hx1_q[gi] <= hx1_d[gi];
        hx2_q[gi] <= hx2_d[gi];
        hy1_q[gi] <= hy1_d[gi];
        hy2_q[gi] <= hy2_d[gi];
      end
    end
  end
endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Scoreboard bench for iir_biquad_tdm: a plain-arithmetic biquad model predicts
// each output when a sample is accepted; a monitor pops and compares on out_valid.
module tb_iir_biquad_tdm;
  localparam int DW   = 12;
  localparam int CW   = 16;
  localparam int FRAC = 11;
  localparam int NCH  = 2;
  localparam int CHW  = 1;
  localparam int YMAX = 2 ** (DW - 1) - 1;
  localparam int YMIN = -(2 ** (DW - 1));

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          coef_we;
  logic [2:0]    coef_sel;
  logic [CW-1:0] coef_data;
  logic          clr_state;

  always #5 clk = ~clk;

  iir_biquad_tdm_if #(.DW(DW), .NCH(NCH)) bus ();

  iir_biquad_tdm #(.DW(DW), .CW(CW), .FRAC(FRAC), .NCH(NCH)) dut (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .coef_we   (coef_we),
    .coef_sel  (coef_sel),
    .coef_data (coef_data),
    .clr_state (clr_state),
    .s_if      (bus)
  );

  typedef struct {
    int     ch;
    int     data;
    bit     sat;
    longint cyc;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     passes = 0;
  longint cyc = 0;
  longint last_acc = 0;
  longint acc_t [4];

  // Reference model state: shadow/active coefficients and per-channel history
  int m_sh [5];
  int m_act [5];
  int mx1 [NCH];
  int mx2 [NCH];
  int my1 [NCH];
  int my2 [NCH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, got, want);
  endtask

  task automatic model_hist_clear();
    for (int i = 0; i < NCH; i++) begin
      mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
    end
  endtask

  task automatic model_reset();
    m_sh[0] = 94; m_sh[1] = 140; m_sh[2] = 94; m_sh[3] = -1213; m_sh[4] = 268;
    model_hist_clear();
  endtask

  task automatic m_write(input int sel, input int val);
    if (sel < 5) m_sh[sel] = val;
  endtask

  // y = sat((b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2 + half) >>> FRAC)
  task automatic model_sample(input int ch, input int x, input longint t);
    longint acc;
    int     y;
    bit     sat;
    exp_t   e;
    for (int k = 0; k < 5; k++) m_act[k] = m_sh[k];
    acc = longint'(m_act[0]) * x + longint'(m_act[1]) * mx1[ch] + longint'(m_act[2]) * mx2[ch]
        - longint'(m_act[3]) * my1[ch] - longint'(m_act[4]) * my2[ch] + longint'(2 ** (FRAC - 1));
    acc = acc >>> FRAC;
    sat = 1'b0;
    if (acc > YMAX) begin y = YMAX; sat = 1'b1; end
    else if (acc < YMIN) begin y = YMIN; sat = 1'b1; end
    else y = int'(acc);
    mx2[ch] = mx1[ch]; mx1[ch] = x;
    my2[ch] = my1[ch]; my1[ch] = y;
    e.ch = ch; e.data = y; e.sat = sat; e.cyc = t + 6;
    exp_q.push_back(e);
  endtask

  // Output monitor: one line per result, compared against the scoreboard head
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      $display("out cyc=%0d ch=%0d data=%0d sat=%0d", cyc, bus.out_ch, bus.out_data, bus.out_sat);
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_out: got ch=%0d data=%0d at cyc %0d, required no output",
                 bus.out_ch, bus.out_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(bus.out_ch) != mon_e.ch || int'(bus.out_data) != mon_e.data ||
            bus.out_sat !== mon_e.sat || cyc != mon_e.cyc)
          $display("FAIL out_result: got ch=%0d data=%0d sat=%0d cyc=%0d, required ch=%0d data=%0d sat=%0d cyc=%0d",
                   bus.out_ch, bus.out_data, bus.out_sat, cyc, mon_e.ch, mon_e.data, mon_e.sat, mon_e.cyc);
        else passes++;
      end
    end
  end

  // Offer one sample (optionally with a same-cycle coef write); called at posedge+1,
  // returns at posedge+1 after the accepting edge.
  task automatic send(input int ch, input int x, input bit hold, input bit wr,
                      input int sel, input int val, input bit track);
    int n;
    longint t;
    bus.in_valid = 1'b1;
    bus.in_ch    = ch[CHW-1:0];
    bus.in_data  = x[DW-1:0];
    if (wr) begin
      coef_we = 1'b1; coef_sel = sel[2:0]; coef_data = val[CW-1:0];
    end
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      if (wr) m_write(sel, val);
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", n);
      @(posedge clk);
    end else begin
      t = cyc;
      @(posedge clk);
      if (track) model_sample(ch, x, t);
      if (wr) m_write(sel, val);
      last_acc = t;
    end
    #1;
    coef_we = 1'b0;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic write_coef(input int sel, input int val);
    coef_we = 1'b1; coef_sel = sel[2:0]; coef_data = val[CW-1:0];
    @(posedge clk);
    m_write(sel, val);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_state = 1'b1;
    @(posedge clk);
    model_hist_clear();
    #1;
    clr_state = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Hold reset two cycles, checking ready and output registers, then release
  task automatic do_reset();
    sys_rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_out_sat", bus.out_sat, 0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    sys_rst = 1'b1;
    @(negedge clk);
    check("rel_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish first");
    $fatal(1);
  end

  initial begin
    int ch, x, sel, val;
    bit wr, hold;
    sys_rst = 1'b0; coef_we = 1'b0; coef_sel = '0; coef_data = '0; clr_state = 1'b0;
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Impulse on ch0 with default coefficients
    send(0, 100, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) send(0, 0, 0, 0, 0, 0, 1);
    drain();

    // Interleaved ch0 impulse and ch1 zeros from clean history
    pulse_clr();
    for (int i = 0; i < 3; i++) begin
      send(0, (i == 0) ? 100 : 0, 0, 0, 0, 0, 1);
      send(1, 0, 0, 0, 0, 0, 1);
    end
    drain();

    // Back-to-back with in_valid held high: one accept every 6 cycles
    for (int i = 0; i < 4; i++) begin
      send(1, int'($urandom_range(0, 4095)) - 2048, (i < 3), 0, 0, 0, 1);
      acc_t[i] = last_acc;
    end
    for (int i = 1; i < 4; i++) check("accept_spacing", acc_t[i] - acc_t[i-1], 6);
    drain();

    // Saturation at both rails
    write_coef(0, 32767);
    for (int k = 1; k < 5; k++) write_coef(k, 0);
    send(1, 2047, 0, 0, 0, 0, 1);
    send(1, -2048, 0, 0, 0, 0, 1);
    drain();

    // Coef write in the acceptance cycle applies only to the following sample
    write_coef(0, 94); write_coef(1, 140); write_coef(2, 94);
    write_coef(3, -1213); write_coef(4, 268);
    pulse_clr();
    send(0, 100, 0, 1, 0, 0, 1);
    send(0, 100, 0, 0, 0, 0, 1);
    drain();
    write_coef(0, 94);

    // clr_state during MAC2 aborts the sample
    send(0, 300, 0, 0, 0, 0, 1);
    drain();
    send(0, 500, 0, 0, 0, 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    pulse_clr();
    @(negedge clk);
    check("clr_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    write_coef(1, 500);
    send(1, 700, 0, 0, 0, 0, 0);
    // Reset during MAC3 discards the sample and restores default coefficients
    repeat (3) begin @(posedge clk); #1; end
    do_reset();
    send(0, 100, 0, 0, 0, 0, 1);
    send(0, 0, 0, 0, 0, 0, 1);
    send(0, 0, 0, 0, 0, 0, 1);
    drain();

    // Random samples, channels and occasional coefficient writes
    for (int i = 0; i < 40; i++) begin
      ch   = int'($urandom_range(0, NCH - 1));
      x    = int'($urandom_range(0, 4095)) - 2048;
      wr   = ($urandom_range(0, 4) == 0);
      sel  = int'($urandom_range(0, 7));
      val  = int'($urandom_range(0, 8191)) - 4096;
      hold = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(ch, x, hold, wr, sel, val, 1);
    end
    drain();
    repeat (10) @(posedge clk);
    #1;
    check("final_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
